// File: rtl/wbc_pvic.sv
// wbc_pvic: prioritised vectored interrupt controller with a Wishbone vector-fetch port.
// Define WBC_PVIC_PASSIVE_EN to answer a fetch that finds no request with the PASSIVE vector.
module wbc_pvic #(
  parameter int           N    = 8,
  parameter int           LW   = 3,
  parameter logic [N-1:0] EDGE = {N{1'b0}}
`ifdef WBC_PVIC_PASSIVE_EN
  ,
  parameter logic [15:0]  PASSIVE = 16'o000000
`endif
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  output logic            wb_irq_o,
  output logic [15:0]     wb_dat_o,
  input  logic            wb_stb_i,
  output logic            wb_ack_o,
  input  logic            wb_una_i,
  output logic [LW-1:0]   wb_lvl_o,
  input  logic [15:0]     rsel,
  input  logic [LW-1:0]   cpu_pri,
  input  logic [N*16-1:0] ivec,
  input  logic [N*LW-1:0] ipri,
  input  logic [N-1:0]    imask,
  input  logic [N-1:0]    ireq,
  output logic [N-1:0]    iack
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  ireq_q, flag_q, flag_d, iack_q, iack_d, pend, elig;
  logic          irq_q, irq_d, ack_q, ack_d;
  logic [15:0]   dat_q, dat_d;
  logic [LW-1:0] lvl_q, lvl_d, nlvl_q, nlvl_d, win_lvl;
  logic [IW-1:0] nvec_q, nvec_d, win_idx;
  logic [LW-1:0] pri_w [N];

  // Flags run on every channel so a set and an iack clear collide identically; only EDGE channels use them.
  assign flag_d = (flag_q & ~iack_q) | (ireq & ~ireq_q);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      assign pri_w[gi] = ipri[gi*LW +: LW];
      assign pend[gi]  = EDGE[gi] ? flag_q[gi] : ireq[gi];
      assign elig[gi]  = pend[gi] & ~imask[gi] & (pri_w[gi] > cpu_pri);
    end
  endgenerate

  // Eligible levels are always nonzero, so starting from 0 needs no separate "found" flag.
  always_comb begin
    win_idx = '0;
    win_lvl = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i] && (pri_w[i] > win_lvl)) begin
        win_idx = IW'(i);
        win_lvl = pri_w[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    irq_d   = 1'b0;
    ack_d   = 1'b0;
    iack_d  = '0;
    dat_d   = dat_q;
    lvl_d   = lvl_q;
    nvec_d  = nvec_q;
    nlvl_d  = nlvl_q;
    case (state_q)
      S_IDLE: begin
        nvec_d = win_idx;
        nlvl_d = win_lvl;
        irq_d  = |elig;
        if (wb_stb_i) begin
          if (wb_una_i) begin
            dat_d   = rsel;
            nvec_d  = nvec_q;
            nlvl_d  = nlvl_q;
            irq_d   = 1'b0;
            state_d = S_ACK;
          end else if (irq_q) begin
            dat_d   = ivec[16*nvec_q +: 16];
            lvl_d   = nlvl_q;
            iack_d  = N'(1) << nvec_q;
            nvec_d  = nvec_q;
            nlvl_d  = nlvl_q;
            irq_d   = 1'b0;
            state_d = S_ACK;
          end
`ifdef WBC_PVIC_PASSIVE_EN
          else begin
            dat_d   = PASSIVE;
            lvl_d   = '0;
            nvec_d  = nvec_q;
            nlvl_d  = nlvl_q;
            irq_d   = 1'b0;
            state_d = S_ACK;
          end
`endif
        end
      end
      S_ACK: begin
        ack_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!wb_stb_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      ireq_q  <= '0;
      flag_q  <= '0;
      iack_q  <= '0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      lvl_q   <= '0;
      nvec_q  <= '0;
      nlvl_q  <= '0;
    end else begin
      state_q <= state_d;
      ireq_q  <= ireq;
      flag_q  <= flag_d;
      iack_q  <= iack_d;
      irq_q   <= irq_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      lvl_q   <= lvl_d;
      nvec_q  <= nvec_d;
      nlvl_q  <= nlvl_d;
    end
  end

  assign wb_irq_o = irq_q;
  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign wb_lvl_o = lvl_q;
  assign iack     = iack_q;

endmodule
